ps2_keyboard_tx: RTL and testbench



---
 rtl/ps2_keyboard_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_keyboard_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_tx.sv
// PS/2 keyboard emulator: turns one ASCII letter into its scan-code set 2 make/break
// byte sequence and shifts it out as 11-bit PS/2 frames on ps2_clk/ps2_data.
module ps2_keyboard_tx #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii,
  input  logic       valid,
  output logic       ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       err
);

  localparam int unsigned HW = $clog2(HALF_PERIOD) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [HW-1:0] HalfLast = HW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GapLast  = GW'(GAP_CYCLES - 1);

  localparam logic [7:0] CodeShift = 8'h12;
  localparam logic [7:0] CodeBreak = 8'hF0;

  typedef enum logic [1:0] {StIdle, StFrame, StGap} state_e;

  state_e        state;
  logic [HW-1:0] half_cnt;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [2:0]    last_idx;
  logic          clk_low;
  // Pending bytes, next byte to send always in [7:0].
  logic [47:0]   seq;

  logic       is_lower;
  logic       is_upper;
  logic [7:0] code;

  // Letters share the low five ASCII bits across cases: 'a'/'A' = 1 .. 'z'/'Z' = 26.
  function automatic logic [7:0] set2_code(input logic [4:0] letter);
    logic [7:0] c;
    case (letter)
      5'd1:    c = 8'h1C;
      5'd2:    c = 8'h32;
      5'd3:    c = 8'h21;
      5'd4:    c = 8'h23;
      5'd5:    c = 8'h24;
      5'd6:    c = 8'h2B;
      5'd7:    c = 8'h34;
      5'd8:    c = 8'h33;
      5'd9:    c = 8'h43;
      5'd10:   c = 8'h3B;
      5'd11:   c = 8'h42;
      5'd12:   c = 8'h4B;
      5'd13:   c = 8'h3A;
      5'd14:   c = 8'h31;
      5'd15:   c = 8'h44;
      5'd16:   c = 8'h4D;
      5'd17:   c = 8'h15;
      5'd18:   c = 8'h2D;
      5'd19:   c = 8'h1B;
      5'd20:   c = 8'h2C;
      5'd21:   c = 8'h3C;
      5'd22:   c = 8'h2A;
      5'd23:   c = 8'h1D;
      5'd24:   c = 8'h22;
      5'd25:   c = 8'h35;
      5'd26:   c = 8'h1A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Frame bit idx: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic       v;
    logic [3:0] di;
    di = idx - 4'd1;
    case (idx)
      4'd0:    v = 1'b0;
      4'd9:    v = ~^b;
      4'd10:   v = 1'b1;
      default: v = b[di[2:0]];
    endcase
    return v;
  endfunction

  always_comb begin
    is_lower = (ascii >= 8'h61) && (ascii <= 8'h7A);
    is_upper = (ascii >= 8'h41) && (ascii <= 8'h5A);
    code     = set2_code(ascii[4:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      ready    <= 1'b1;
      busy     <= 1'b0;
      err      <= 1'b0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      half_cnt <= '0;
      gap_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      last_idx <= '0;
      clk_low  <= 1'b0;
      seq      <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (valid) begin
            if (is_lower || is_upper) begin
              state    <= StFrame;
              ready    <= 1'b0;
              busy     <= 1'b1;
              byte_idx <= '0;
              bit_idx  <= '0;
              half_cnt <= '0;
              clk_low  <= 1'b0;
              ps2_clk  <= 1'b1;
              ps2_data <= 1'b0;
              if (is_upper) begin
                seq      <= {CodeShift, CodeBreak, code, CodeBreak, code, CodeShift};
                last_idx <= 3'd5;
              end else begin
                seq      <= {24'h000000, code, CodeBreak, code};
                last_idx <= 3'd2;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end

        StFrame: begin
          if (half_cnt == HalfLast) begin
            half_cnt <= '0;
            if (!clk_low) begin
              clk_low <= 1'b1;
              ps2_clk <= 1'b0;
            end else begin
              clk_low <= 1'b0;
              ps2_clk <= 1'b1;
              if (bit_idx == 4'd10) begin
                state    <= StGap;
                gap_cnt  <= '0;
                bit_idx  <= '0;
                ps2_data <= 1'b1;
              end else begin
                bit_idx  <= bit_idx + 4'd1;
                ps2_data <= frame_bit(seq[7:0], bit_idx + 4'd1);
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        StGap: begin
          if (gap_cnt == GapLast) begin
            gap_cnt <= '0;
            if (byte_idx == last_idx) begin
              state <= StIdle;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= StFrame;
              byte_idx <= byte_idx + 3'd1;
              seq      <= {8'h00, seq[47:8]};
              half_cnt <= '0;
              clk_low  <= 1'b0;
              ps2_data <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: a line monitor decodes frames at ps2_clk falling edges and
// table-driven character vectors plus hand sequences compare them to expected byte streams.
module tb_ps2_keyboard_tx;

  localparam int unsigned HP  = 2;
  localparam int unsigned GAP = 4;
  localparam int FRAME_CYC = 22 * HP + GAP;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ascii;
  logic       valid;
  logic       ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       err;

  ps2_keyboard_tx #(
    .HALF_PERIOD(HP),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ascii   (ascii),
    .valid   (valid),
    .ready   (ready),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Line monitor state, sampled on the falling system clock edge.
  logic [10:0] frames[$];
  int          gaps[$];
  logic [10:0] fr = '0;
  int          bit_cnt = 0;
  int          run = 0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  int          busy_cnt = 0;
  int          err_cnt = 0;
  int          ready_low = 0;
  int          line_low = 0;
  int          glitches = 0;

  always @(negedge clk) begin
    if (rst) begin
      bit_cnt   = 0;
      run       = 0;
      prev_clk  = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (!ready) ready_low++;
      if (!(ps2_clk && ps2_data)) line_low++;
      if (prev_clk && !ps2_clk) begin
        fr = {ps2_data, fr[10:1]};
        bit_cnt++;
        if (bit_cnt == 11) begin
          frames.push_back(fr);
          bit_cnt = 0;
        end
      end
      if (!prev_clk && !ps2_clk && (ps2_data !== prev_data)) glitches++;
      if (ps2_clk && ps2_data) begin
        run++;
      end else begin
        if (ps2_clk && !ps2_data && bit_cnt == 0 && run > 0) gaps.push_back(run);
        run = 0;
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Returns #2 after the acceptance edge, i.e. in the first cycle after acceptance.
  task automatic send(input logic [7:0] ch);
    ascii = ch;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while (!(ready && !busy) && k < limit) begin
      step(1);
      k++;
    end
    chk({name, " reaches idle"}, 32'(ready && !busy), 32'd1);
  endtask

  task automatic chk_stream(input string name, input int n, input logic [47:0] bytes);
    chk({name, " frame count"}, 32'(frames.size()), 32'(n));
    for (int j = 0; j < n; j++) begin
      if (j < frames.size())
        chk($sformatf("%s frame%0d", name, j), 32'(frames[j]),
            32'(mk_frame(bytes[47-8*j -: 8])));
    end
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic        bad;
    int          n;
    logic [47:0] bytes;  // first byte in the top octet
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h61, 1'b0, 3, 48'h1CF01C000000};  // a
    vecs[1] = '{8'h42, 1'b0, 6, 48'h1232F032F012};  // B
    vecs[2] = '{8'h31, 1'b1, 0, 48'h0};             // 1
    vecs[3] = '{8'h7A, 1'b0, 3, 48'h1AF01A000000};  // z
    vecs[4] = '{8'h41, 1'b0, 6, 48'h121CF01CF012};  // A
    vecs[5] = '{8'h5A, 1'b0, 6, 48'h121AF01AF012};  // Z
    vecs[6] = '{8'h40, 1'b1, 0, 48'h0};             // @
    vecs[7] = '{8'h5B, 1'b1, 0, 48'h0};             // [
    vecs[8] = '{8'h60, 1'b1, 0, 48'h0};             // `
    vecs[9] = '{8'h7B, 1'b1, 0, 48'h0};             // {

    rst   = 1'b1;
    valid = 1'b0;
    ascii = 8'h00;
    step(2);
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset ps2_clk", 32'(ps2_clk), 32'd1);
    chk("reset ps2_data", 32'(ps2_data), 32'd1);
    rst = 1'b0;
    step(3);

    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("v%0d(%0h)", i, vecs[i].ch);
      frames.delete();
      busy_cnt  = 0;
      err_cnt   = 0;
      ready_low = 0;
      line_low  = 0;
      send(vecs[i].ch);
      chk({nm, " err after accept"}, 32'(err), 32'(vecs[i].bad));
      chk({nm, " busy after accept"}, 32'(busy), 32'(!vecs[i].bad));
      if (vecs[i].bad) begin
        step(100);
        chk({nm, " err cycles"}, 32'(err_cnt), 32'd1);
        chk({nm, " ready low cycles"}, 32'(ready_low), 32'd0);
        chk({nm, " line activity"}, 32'(line_low), 32'd0);
        chk({nm, " frame count"}, 32'(frames.size()), 32'd0);
      end else begin
        wait_idle(nm, 1000);
        step(4);
        chk({nm, " busy cycles"}, 32'(busy_cnt), 32'(vecs[i].n * FRAME_CYC));
        chk({nm, " err cycles"}, 32'(err_cnt), 32'd0);
        chk_stream(nm, vecs[i].n, vecs[i].bytes);
      end
    end

    // 'c' with a 'z' offered mid-transmission: the second request must be dropped.
    frames.delete();
    send(8'h63);
    step(30);
    chk("c ready low mid-tx", 32'(ready), 32'd0);
    ascii = 8'h7A;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
    ascii = 8'h00;
    wait_idle("c", 1000);
    step(20);
    chk("c no follow-on", 32'(busy), 32'd0);
    chk_stream("c", 3, 48'h21F021000000);

    // Reset during bit 5 of the second frame of 'a' (clock-low half, cycle 48+20+2).
    frames.delete();
    send(8'h61);
    step(70);
    chk("rst pre ps2_clk low", 32'(ps2_clk), 32'd0);
    chk("rst pre frames done", 32'(frames.size()), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst async ps2_clk", 32'(ps2_clk), 32'd1);
    chk("rst async ps2_data", 32'(ps2_data), 32'd1);
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async ready", 32'(ready), 32'd1);
    step(2);
    rst = 1'b0;
    step(2);
    frames.delete();
    send(8'h7A);
    wait_idle("post-rst z", 1000);
    step(4);
    chk_stream("post-rst z", 3, 48'h1AF01A000000);

    // Back-to-back: valid held through 'a', switched to 'b' in the cycle ready returns.
    frames.delete();
    gaps.delete();
    ascii = 8'h61;
    valid = 1'b1;
    step(1);
    begin
      int k = 0;
      while (!ready && k < 1000) begin
        step(1);
        k++;
      end
    end
    chk("b2b ready returns", 32'(ready), 32'd1);
    chk("b2b busy low at return", 32'(busy), 32'd0);
    ascii = 8'h62;
    step(1);
    valid = 1'b0;
    chk("b2b second accepted", 32'(busy), 32'd1);
    wait_idle("b2b", 2000);
    step(4);
    chk_stream("b2b a", 6, 48'h1CF01C32F032);
    // Between the two sequences the lines idle for the GAP state plus the accept cycle.
    chk("b2b gap count", 32'(gaps.size()), 32'd6);
    if (gaps.size() == 6) begin
      chk("b2b gap1", 32'(gaps[1]), 32'(GAP));
      chk("b2b gap2", 32'(gaps[2]), 32'(GAP));
      chk("b2b gap3", 32'(gaps[3]), 32'(GAP + 1));
      chk("b2b gap4", 32'(gaps[4]), 32'(GAP));
      chk("b2b gap5", 32'(gaps[5]), 32'(GAP));
    end

    chk("data stable while ps2_clk low", 32'(glitches), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
